// File: rtl/frame_downloader_if.sv
// ---------------------------------------------------------------------------
// frame_downloader_if
// Groups the frame downloader's control, memory and pixel-queue signals.
//   start/base_addr          : begin one frame read at a pixel-unit address
//   read_rq/read_ack         : memory arbitration request and grant
//   mem_rd_en/read_addr      : one-cycle burst read command and its address
//   read_data/read_data_valid: returned burst words
//   queue_full/queue_wr_en/queue_data : tagged 17-bit pixel stream
//   download_done/read_error : frame complete pulse, sticky burst timeout
// Handshake rule: queue_data is a word offered to the queue; it is taken in
// exactly the cycles where queue_wr_en=1 (only possible while queue_full=0),
// and it holds its value for as long as queue_full keeps it from being taken.
// modport master = downloader side, modport slave = memory/queue side.
// ---------------------------------------------------------------------------
interface frame_downloader_if;
    logic        start;
    logic [20:0] base_addr;
    logic        read_rq;
    logic        read_ack;
    logic        mem_rd_en;
    logic [20:0] read_addr;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        queue_full;
    logic        queue_wr_en;
    logic [16:0] queue_data;
    logic        download_done;
    logic        read_error;

    modport master (
        input  start, base_addr, read_ack, read_data, read_data_valid, queue_full,
        output read_rq, mem_rd_en, read_addr, queue_wr_en, queue_data,
               download_done, read_error
    );

    modport slave (
        output start, base_addr, read_ack, read_data, read_data_valid, queue_full,
        input  read_rq, mem_rd_en, read_addr, queue_wr_en, queue_data,
               download_done, read_error
    );
endinterface

// File: rtl/frame_downloader.sv
// ---------------------------------------------------------------------------
// frame_downloader
// Reads a FRAME_WIDTH x FRAME_HEIGHT frame of 16-bit pixels from memory in
// bursts of MEMORY_BURST bytes and streams it into a pixel queue as tagged
// 17-bit words: 17'h10000 frame start, 17'h10001 row start, 17'h1FFFF frame
// end, {1'b0, pixel} for data. Assumes MEMORY_BURST >= 8 and a power of two.
// Ports:
//   clk       : single clock, rising edge
//   reset     : synchronous, active-high
//   bus       : frame_downloader_if.master (control, memory, queue signals)
//   state_dbg : current FSM state encoding
// Optional feature: define FRAME_DOWNLOADER_TIMEOUT_EN to abort a burst that
// has not delivered all its words 32 cycles after mem_rd_en; the frame is then
// closed with the end tag and read_error stays set until reset. Without the
// macro the downloader waits for data indefinitely and read_error is 0.
// ---------------------------------------------------------------------------
module frame_downloader #(
    parameter int MEMORY_BURST = 32,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic               clk,
    input  logic               reset,
    frame_downloader_if.master bus,
    output logic [3:0]         state_dbg
);
    localparam int WPB = MEMORY_BURST / 4;          // words per burst
    localparam int PPB = MEMORY_BURST / 2;          // pixels per burst
    localparam int PIW = $clog2(PPB);
    localparam int WIW = PIW - 1;
    localparam int CW  = $clog2(FRAME_WIDTH + 1);
    localparam int RW  = $clog2(FRAME_HEIGHT + 1);

    localparam logic [16:0] TAG_FS = 17'h10000;
    localparam logic [16:0] TAG_RS = 17'h10001;
    localparam logic [16:0] TAG_FE = 17'h1FFFF;

    typedef enum logic [3:0] {
        IDLE, FRAME_START, ROW_START, READ_REQ, READ_CMD,
        READ_DATA, DRAIN, ROW_CHECK, FRAME_END, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [20:0]     addr_q, addr_d;
    logic [20:0]     rd_addr_q, rd_addr_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [WIW-1:0]  widx_q, widx_d;
    logic [PIW-1:0]  pix_idx_q, pix_idx_d;
    logic            pend_q, pend_d;
    logic [16:0]     qdata_q, qdata_d;
    logic [31:0]     word_buf_q [WPB];
    logic [31:0]     word_buf_d [WPB];
`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
    logic [4:0]      tmo_q, tmo_d;
    logic            err_q, err_d;
`endif

    logic            can_load;
    logic [CW-1:0]   rem, n_pix;
    logic [31:0]     cur_word;
    logic [15:0]     cur_pix;

    // The pending word slot can take a new word when empty or when its
    // current word leaves this very cycle.
    assign can_load = !pend_q || !bus.queue_full;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_addr_d  = rd_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        widx_d     = widx_q;
        pix_idx_d  = pix_idx_q;
        pend_d     = pend_q && bus.queue_full;
        qdata_d    = qdata_q;
        word_buf_d = word_buf_q;
`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
        tmo_d      = tmo_q;
        err_d      = err_q;
`endif
        // Pixels left in this row, clipped to one burst.
        rem      = CW'(FRAME_WIDTH) - col_q;
        n_pix    = (32'(rem) < PPB) ? rem : CW'(PPB);
        cur_word = word_buf_q[pix_idx_q[PIW-1:1]];
        cur_pix  = pix_idx_q[0] ? cur_word[31:16] : cur_word[15:0];

        case (state_q)
            IDLE: if (bus.start) begin
                addr_d  = bus.base_addr;
                col_d   = '0;
                row_d   = '0;
                state_d = FRAME_START;
            end
            FRAME_START: if (can_load) begin
                pend_d  = 1'b1;
                qdata_d = TAG_FS;
                state_d = ROW_START;
            end
            ROW_START: if (can_load) begin
                pend_d  = 1'b1;
                qdata_d = TAG_RS;
                state_d = READ_REQ;
            end
            READ_REQ: if (bus.read_ack) begin
                rd_addr_d = addr_q;
                state_d   = READ_CMD;
            end
            READ_CMD: begin
                widx_d  = '0;
`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = READ_DATA;
            end
            READ_DATA: begin
                if (bus.read_data_valid) begin
                    word_buf_d[widx_q] = bus.read_data;
                    widx_d             = widx_q + WIW'(1);
                end
                if (bus.read_data_valid && 32'(widx_q) == WPB - 1) begin
                    widx_d    = '0;
                    pix_idx_d = '0;
                    state_d   = DRAIN;
                end
`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
                // 32nd READ_DATA cycle without the last word: abandon frame.
                else if (tmo_q == 5'd31) begin
                    err_d   = 1'b1;
                    widx_d  = '0;
                    state_d = FRAME_END;
                end else begin
                    tmo_d = tmo_q + 5'd1;
                end
`endif
            end
            DRAIN: if (can_load) begin
                pend_d  = 1'b1;
                qdata_d = {1'b0, cur_pix};
                if (32'(pix_idx_q) + 32'd1 >= 32'(n_pix)) begin
                    addr_d    = addr_q + 21'(n_pix);
                    col_d     = col_q + n_pix;
                    pix_idx_d = '0;
                    state_d   = ROW_CHECK;
                end else begin
                    pix_idx_d = pix_idx_q + PIW'(1);
                end
            end
            ROW_CHECK: begin
                if (32'(col_q) < FRAME_WIDTH) begin
                    state_d = READ_REQ;
                end else begin
                    col_d   = '0;
                    row_d   = row_q + RW'(1);
                    state_d = (32'(row_q) + 32'd1 == FRAME_HEIGHT) ? FRAME_END : ROW_START;
                end
            end
            FRAME_END: if (can_load) begin
                pend_d  = 1'b1;
                qdata_d = TAG_FE;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_addr_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            widx_q    <= '0;
            pix_idx_q <= '0;
            pend_q    <= 1'b0;
            qdata_q   <= '0;
`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_addr_q <= rd_addr_d;
            col_q     <= col_d;
            row_q     <= row_d;
            widx_q    <= widx_d;
            pix_idx_q <= pix_idx_d;
            pend_q    <= pend_d;
            qdata_q   <= qdata_d;
`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    // Burst buffer contents are only meaningful after a full capture.
    always_ff @(posedge clk) begin
        word_buf_q <= word_buf_d;
    end

    assign bus.read_rq       = (state_q == READ_REQ) || (state_q == READ_CMD) ||
                               (state_q == READ_DATA);
    assign bus.mem_rd_en     = (state_q == READ_CMD);
    assign bus.read_addr     = rd_addr_q;
    assign bus.queue_wr_en   = pend_q && !bus.queue_full;
    assign bus.queue_data    = qdata_q;
    assign bus.download_done = (state_q == DONE);
`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
    assign bus.read_error    = err_q;
`else
    assign bus.read_error    = 1'b0;
`endif
    assign state_dbg         = state_q;
endmodule

// File: tb/tb_frame_downloader.sv
`timescale 1ns/1ps
module tb_frame_downloader;
    localparam int W   = 20;
    localparam int H   = 2;
    localparam int MB  = 32;
    localparam int PPB = MB / 2;
    localparam int WPB = MB / 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state_dbg;

    frame_downloader_if bus();

    frame_downloader #(.MEMORY_BURST(MB), .FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          mem_words = 0;
    int          done_cnt = 0;
    logic [16:0] exp_q[$];
    logic [20:0] exp_addr_q[$];
    logic [15:0] seed_lo, seed_hi;
    bit          mem_short = 0;
    bit          hold_req = 0;
    bit          rand_full = 0;
    bit          rand_gap = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory content: a pixel at pixel address a.
    function automatic logic [15:0] pix(logic [20:0] a);
        return (a[0] ? seed_hi : seed_lo) ^ a[16:1];
    endfunction

    // Reference: frame is W*H contiguous pixels, bursts start every PPB columns.
    task automatic model_frame(logic [20:0] base);
        logic [20:0] a;
        exp_q.push_back(17'h10000);
        for (int r = 0; r < H; r++) begin
            exp_q.push_back(17'h10001);
            for (int c = 0; c < W; c++) begin
                a = base + 21'(r * W + c);
                exp_q.push_back({1'b0, pix(a)});
                if (c % PPB == 0) exp_addr_q.push_back(a);
            end
        end
        exp_q.push_back(17'h1FFFF);
    endtask

    task automatic pulse_start(logic [20:0] base);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.base_addr = base;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.base_addr = 21'($urandom);
    endtask

    task automatic wait_done(string name);
        int n;
        int cyc;
        n = done_cnt;
        cyc = 0;
        while (done_cnt == n && cyc < 20000) begin @(negedge clk); cyc++; end
        check({name, "_done_seen"}, 32'(cyc < 20000), 32'd1);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin @(negedge clk); cyc++; end
        check({name, "_stream_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic run_frame(string name, logic [20:0] base, bit chk_lat);
        model_frame(base);
        pulse_start(base);
        if (chk_lat) begin
            @(negedge clk);
            check("lat_cycle1_wr_en", 32'(bus.queue_wr_en), 32'd0);
            @(negedge clk);
            check("lat_cycle2_wr_en", 32'(bus.queue_wr_en), 32'd1);
            check("lat_first_tag", 32'(bus.queue_data), 32'h10000);
        end
        // A second start mid-frame must be ignored.
        repeat (3) @(posedge clk);
        pulse_start(21'($urandom));
        wait_done(name);
    endtask

    // Scoreboard monitor.
    initial begin : monitor
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.queue_wr_en) begin
                check("wr_while_full", 32'(bus.queue_full), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none", bus.queue_data);
                end else begin
                    check("queue_data", 32'(bus.queue_data), 32'(exp_q.pop_front()));
                end
            end
            if (bus.download_done) begin
                done_cnt++;
                check("done_single_cycle", 32'(prev_done), 32'd0);
            end
            prev_done = bus.download_done;
        end
    end

    initial begin : ack_drv
        bus.read_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.read_ack = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin : full_drv
        logic [16:0] held;
        bus.queue_full = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold_req && bus.queue_wr_en && !bus.queue_data[16]) begin
                hold_req = 1'b0;
                held = bus.queue_data;
                bus.queue_full = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("hold_wr_en", 32'(bus.queue_wr_en), 32'd0);
                    check("hold_data", 32'(bus.queue_data), 32'(held));
                    @(posedge clk); #1;
                end
                bus.queue_full = 1'b0;
                @(negedge clk);
                check("release_wr_en", 32'(bus.queue_wr_en), 32'd1);
                check("release_data", 32'(bus.queue_data), 32'(held));
            end else begin
                bus.queue_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    // Memory: answers each mem_rd_en with a burst from the cycle after; drives
    // junk read_data_valid whenever no burst is in flight.
    initial begin : mem_drv
        logic [20:0] a;
        int cyc;
        bus.read_data_valid = 1'b0;
        bus.read_data = '0;
        forever begin
            @(posedge clk); #1;
            bus.read_data_valid = ($urandom_range(0, 3) == 0);
            bus.read_data = $urandom;
            if (bus.mem_rd_en && !reset) begin
                a = bus.read_addr;
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got %0h expected none", a);
                end else begin
                    check("read_addr", 32'(a), 32'(exp_addr_q.pop_front()));
                end
                mem_words = 0;
                cyc = 0;
                while (mem_words < (mem_short ? 5 : WPB)) begin
                    @(posedge clk); #1;
                    cyc++;
                    if (reset) break;
                    if (rand_gap && $urandom_range(0, 2) == 0) begin
                        bus.read_data_valid = 1'b0;
                        bus.read_data = $urandom;
                    end else begin
                        bus.read_data_valid = 1'b1;
                        bus.read_data = {pix(a + 21'(2 * mem_words + 1)), pix(a + 21'(2 * mem_words))};
                        mem_words++;
                    end
                end
`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
                if (mem_short && !reset) begin
                    while (cyc < 33) begin
                        @(posedge clk); #1;
                        cyc++;
                        bus.read_data_valid = 1'b0;
                        if (cyc == 32) check("tmo_rq_before", 32'(bus.read_rq), 32'd1);
                    end
                    check("tmo_rq_after", 32'(bus.read_rq), 32'd0);
                    check("tmo_read_error", 32'(bus.read_error), 32'd1);
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        logic [20:0] base;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        seed_lo = 16'hAA2A;   // word at 0x100 becomes 0xBBBBAAAA
        seed_hi = 16'hBB3B;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read_rq", 32'(bus.read_rq), 32'd0);
        check("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check("rst_read_addr", 32'(bus.read_addr), 32'd0);
        check("rst_queue_wr_en", 32'(bus.queue_wr_en), 32'd0);
        check("rst_queue_data", 32'(bus.queue_data), 32'd0);
        check("rst_download_done", 32'(bus.download_done), 32'd0);
        check("rst_read_error", 32'(bus.read_error), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Zero-latency memory, no backpressure, known first word.
        run_frame("f1_basic", 21'h100, 1'b1);

        // Random gaps and backpressure, plus one long stall mid-drain.
        seed_lo = 16'($urandom);
        seed_hi = 16'($urandom);
        rand_full = 1'b1;
        rand_gap = 1'b1;
        hold_req = 1'b1;
        run_frame("f2_stall", 21'($urandom), 1'b0);
        hold_req = 1'b0;

        // Reset while the fourth word of a burst is being returned.
        rand_gap = 1'b0;
        base = 21'($urandom);
        model_frame(base);
        pulse_start(base);
        cyc = 0;
        while (mem_words != 4 && cyc < 2000) begin @(posedge clk); #2; cyc++; end
        check("rst_mid_burst_reached", 32'(cyc < 2000), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_read_rq", 32'(bus.read_rq), 32'd0);
        check("mid_rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check("mid_rst_wr_en", 32'(bus.queue_wr_en), 32'd0);
        check("mid_rst_queue_data", 32'(bus.queue_data), 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        reset = 1'b0;
        rand_gap = 1'b1;
        run_frame("f3_after_reset", 21'($urandom), 1'b0);

        // Address wrap at the top of the 21-bit space.
        run_frame("f4_wrap", 21'h1FFFF8, 1'b0);

        for (int i = 0; i < 2; i++) begin
            seed_lo = 16'($urandom);
            seed_hi = 16'($urandom);
            run_frame("f_rand", 21'($urandom), 1'b0);
        end

`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
        // Burst that never completes: frame is closed with the end tag.
        rand_full = 1'b0;
        rand_gap = 1'b0;
        mem_short = 1'b1;
        base = 21'($urandom);
        exp_q.push_back(17'h10000);
        exp_q.push_back(17'h10001);
        exp_q.push_back(17'h1FFFF);
        exp_addr_q.push_back(base);
        pulse_start(base);
        wait_done("f_timeout");
        check("tmo_error_sticky", 32'(bus.read_error), 32'd1);
        mem_short = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("tmo_error_cleared", 32'(bus.read_error), 32'd0);
`else
        check("read_error_tied", 32'(bus.read_error), 32'd0);
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_downloader.md
FRAME_DOWNLOADER -- requirements
Module: frame_downloader

Interface
REQ-001 SHALL have parameter MEMORY_BURST, default 32, burst size in bytes (MEMORY_BURST/4 32-bit words, MEMORY_BURST/2 pixels per burst).
REQ-002 SHALL have parameter FRAME_WIDTH, default 640, pixels per row.
REQ-003 SHALL have parameter FRAME_HEIGHT, default 480, rows per frame.
REQ-004 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: start  in  1  begin one frame read | base_addr  in  21  frame base, pixel-unit address.
REQ-007 SHALL have ports: read_rq  out  1  memory arbitration request | read_ack  in  1  grant, sampled while read_rq high.
REQ-008 SHALL have ports: mem_rd_en  out  1  one-cycle read command | read_addr  out  21  burst start address.
REQ-009 SHALL have ports: read_data  in  32  burst word | read_data_valid  in  1  read_data qualifier.
REQ-010 SHALL have ports: queue_full  in  1 | queue_wr_en  out  1 | queue_data  out  17  tagged pixel stream.
REQ-011 SHALL have ports: download_done  out  1  frame complete pulse | read_error  out  1  sticky burst timeout flag.

Function
REQ-012 Stream SHALL use tags: 17'h10000 frame start, 17'h10001 row start, 17'h1FFFF frame end, {1'b0,pixel[15:0]} data.
REQ-013 States SHALL be IDLE, FRAME_START, ROW_START, READ_REQ, READ_CMD, READ_DATA, DRAIN, ROW_CHECK, FRAME_END, DONE.
REQ-014 IDLE: start=1 SHALL latch base_addr into address counter, clear row/col counters, go FRAME_START; start ignored in all other states.
REQ-015 FRAME_START/ROW_START/FRAME_END SHALL each write one tag when queue_full=0, then advance (FRAME_START->ROW_START, ROW_START->READ_REQ, FRAME_END->DONE).
REQ-016 queue_wr_en SHALL be high only in cycles where queue_full=0 and a word is pending; pending word and queue_data SHALL hold while full; no word lost or duplicated.
REQ-017 READ_REQ: read_rq SHALL rise; on read_ack=1 -> READ_CMD.
REQ-018 READ_CMD: mem_rd_en SHALL pulse exactly one cycle with read_addr = address counter; -> READ_DATA.
REQ-019 READ_DATA SHALL capture MEMORY_BURST/4 words into local buffer on read_data_valid cycles (gaps allowed); after last word read_rq SHALL fall, -> DRAIN.
REQ-020 Word order: read_data[15:0] SHALL be emitted before read_data[31:16]; words in arrival order.
REQ-021 Burst pixel count n = min(MEMORY_BURST/2, FRAME_WIDTH - col); DRAIN SHALL emit exactly n pixels, discard the rest.
REQ-022 After DRAIN, address counter and col SHALL advance by n (21-bit wrap modulo 2^21); -> ROW_CHECK.
REQ-023 ROW_CHECK: col<FRAME_WIDTH -> READ_REQ; else row+1, col=0; row==FRAME_HEIGHT -> FRAME_END else ROW_START.
REQ-024 DONE: download_done SHALL be high exactly one cycle; -> IDLE.
REQ-025 read_data_valid outside READ_DATA SHALL be ignored; read_ack outside READ_REQ SHALL be ignored.
REQ-026 Start-to-first-queue-write latency SHALL be 2 cycles with queue_full=0.

Reset
REQ-027 reset=1 SHALL force IDLE from any state, mid-burst included, on the next clk edge.
REQ-028 Reset values: read_rq=0, mem_rd_en=0, read_addr=0, queue_wr_en=0, queue_data=0, download_done=0, read_error=0; counters and buffer index 0.

Configuration
REQ-029 Macro FRAME_DOWNLOADER_TIMEOUT_EN defined: READ_DATA exceeding 32 cycles after mem_rd_en without all words SHALL drop read_rq, set read_error (cleared only by reset), go FRAME_END, emit 17'h1FFFF, pulse download_done.
REQ-030 Macro undefined: READ_DATA SHALL wait indefinitely; read_error tied 0.

Verification
REQ-031 FRAME_WIDTH=20, FRAME_HEIGHT=2, base_addr=0x100, zero-latency memory -> stream 10000,10001,20 px,10001,20 px,1FFFF; read_addr 0x100,0x110,0x114,0x124; download_done one pulse.
REQ-032 Word 0xBBBBAAAA first in burst -> pixels 0x0AAAA then 0x0BBBB.
REQ-033 queue_full held high 10 cycles mid-DRAIN -> queue_wr_en low throughout, same 17-bit word emitted first after release, pixel count unchanged.
REQ-034 reset=1 during READ_DATA word 3 -> next cycle IDLE, read_rq=0; following start yields complete correct frame.
REQ-035 TIMEOUT_EN, only 5 of 8 words returned -> at cycle 33 read_rq=0, read_error=1, 17'h1FFFF emitted, download_done pulses.
REQ-036 base_addr=0x1FFFF8, FRAME_WIDTH=32, FRAME_HEIGHT=1 -> read_addr 0x1FFFF8 then 0x000008.
